// File: rtl/conv_pkg.sv
// conv_pkg: shared pixel type, frame defaults and 3x3 window index constants
package conv_pkg;
  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int P_TL = 0, P_TC = 1, P_TR = 2;
  localparam int P_ML = 3, P_MC = 4, P_MR = 5;
  localparam int P_BL = 6, P_BC = 7, P_BR = 8;
  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/window_generator_if.sv
// window_generator_if: pixel stream in, registered 3x3 window out
interface window_generator_if;
  import conv_pkg::*;
  pix_t pix_in;
  logic pix_valid;
  logic pix_ready;
  pix_t p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic win_valid;
  logic win_ready;
  logic frame_done;
  modport master (output pix_in, pix_valid, win_ready,
                  input  pix_ready, p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, frame_done);
  modport slave  (input  pix_in, pix_valid, win_ready,
                  output pix_ready, p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, frame_done);
endinterface

// File: rtl/window_generator_line_ram.sv
// line_ram: one image row of pixels, async read, write on we
module line_ram
  import conv_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  pix_t                     i_wdata,
  output pix_t                     o_rdata
);
  pix_t r_mem [DEPTH];
  assign o_rdata = r_mem[i_addr];
  // row storage, contents left unreset since validity masks stale data
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/window_generator.sv
// window_generator: streaming 3x3 neighbourhood generator over a raster pixel stream
module window_generator
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input logic               clk,
  input logic               rst,
  window_generator_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pix_t          r_win [9];
  logic          r_win_valid, r_frame_done;
  pix_t          w_lb0, w_lb1;
  logic          w_accept, w_col_last, w_row_last;
  assign bus.pix_ready = !r_win_valid || bus.win_ready;
  assign w_accept      = bus.pix_valid && bus.pix_ready;
  assign w_col_last    = r_col == CW'(IMG_W - 1);
  assign w_row_last    = r_row == RW'(IMG_H - 1);
  line_ram #(.DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .i_we(w_accept), .i_addr(r_col), .i_wdata(w_lb1), .o_rdata(w_lb0)
  );
  line_ram #(.DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .i_we(w_accept), .i_addr(r_col), .i_wdata(bus.pix_in), .o_rdata(w_lb1)
  );
  // raster counters, window shift register and one-deep output handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win        <= '{default: '0};
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;
      if (w_accept) begin
        r_col       <= w_col_last ? '0 : r_col + 1'b1;
        r_row       <= w_col_last ? (w_row_last ? '0 : r_row + 1'b1) : r_row;
        r_win_valid <= r_row >= RW'(2) && r_col >= CW'(2);
        r_win[P_TL] <= r_win[P_TC];
        r_win[P_TC] <= r_win[P_TR];
        r_win[P_TR] <= w_lb0;
        r_win[P_ML] <= r_win[P_MC];
        r_win[P_MC] <= r_win[P_MR];
        r_win[P_MR] <= w_lb1;
        r_win[P_BL] <= r_win[P_BC];
        r_win[P_BC] <= r_win[P_BR];
        r_win[P_BR] <= bus.pix_in;
      end else if (bus.win_ready) r_win_valid <= 1'b0;
    end
  assign bus.p0         = r_win[P_TL];
  assign bus.p1         = r_win[P_TC];
  assign bus.p2         = r_win[P_TR];
  assign bus.p3         = r_win[P_ML];
  assign bus.p4         = r_win[P_MC];
  assign bus.p5         = r_win[P_MR];
  assign bus.p6         = r_win[P_BL];
  assign bus.p7         = r_win[P_BC];
  assign bus.p8         = r_win[P_BR];
  assign bus.win_valid  = r_win_valid;
  assign bus.frame_done = r_frame_done;
endmodule
